axis_frame_source: RTL and testbench

AXI-Stream master that generates one frame per start request: `frame_len` beats of incrementing data beginning at `seed`, with `tlast` on the final beat. It drives the master side of the stream protocol and feeds register slices and stream consumers in the pipeline. It is used both as a traffic source in benches and as the frame emitter for control logic. Full throughput: one beat per cycle while the sink holds `tready` high.

---
 rtl/axis_frame_source.sv | 82 ++++++++
 tb/tb_axis_frame_source.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_source.sv
// AXI-Stream frame generator: frame_len beats of seed, seed+1, ... with tlast on the final beat.
// First beat is valid the cycle after start is taken; tready low stalls the current beat in place.
module axis_frame_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] idx_next;
    logic                 next_is_last;

    // tlast for the following beat is precomputed so it can leave a register
    always_comb begin
        idx_next     = idx + LEN_WIDTH'(1);
        next_is_last = (idx_next == len_q - LEN_WIDTH'(1));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            len_q         <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frames_sent   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (frame_len != '0)) begin
                        state         <= SEND;
                        len_q         <= frame_len;
                        idx           <= '0;
                        busy          <= 1'b1;
                        m_axis_tdata  <= seed;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (frame_len == LEN_WIDTH'(1));
                    end
                end
                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            frames_sent   <= frames_sent + CNT_WIDTH'(1);
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            idx           <= idx_next;
                            m_axis_tdata  <= m_axis_tdata + DATA_WIDTH'(1);
                            m_axis_tlast  <= next_is_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source: stimulus pushes expected beats/counts, a negedge monitor pops and compares.
module tb_axis_frame_source;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 2;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [DW-1:0] seed = '0;
    logic          m_axis_tready = 1'b0;
    logic          busy, done, m_axis_tvalid, m_axis_tlast;
    logic [CW-1:0] frames_sent;
    logic [DW-1:0] m_axis_tdata;

    axis_frame_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .frame_len(frame_len), .seed(seed),
        .busy(busy), .done(done), .frames_sent(frames_sent),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_beats[$];
    logic [CW-1:0] exp_done[$];
    logic [CW-1:0] model_cnt = '0;
    int            checks = 0;
    int            errors = 0;
    int            hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: beat scoreboard, stall stability, done/frames_sent scoreboard
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_dat;
    logic          stall_last;
    beat_t         b;
    logic [CW-1:0] ecnt;

    always @(negedge aclk) begin
        if (areset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'(1));
                chk("hold_data", 64'(m_axis_tdata), 64'(stall_dat));
                chk("hold_last", 64'(m_axis_tlast), 64'(stall_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs++;
                stall_q = 1'b0;
                if (exp_beats.size() == 0) begin
                    chk("extra_beat", 64'(exp_beats.size()), 64'(1));
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_data", 64'(m_axis_tdata), 64'(b.data));
                    chk("beat_last", 64'(m_axis_tlast), 64'(b.last));
                end
            end else if (m_axis_tvalid) begin
                stall_q    = 1'b1;
                stall_dat  = m_axis_tdata;
                stall_last = m_axis_tlast;
            end else begin
                stall_q = 1'b0;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("spurious_done", 64'(exp_done.size()), 64'(1));
                end else begin
                    ecnt = exp_done.pop_front();
                    chk("frames_sent", 64'(frames_sent), 64'(ecnt));
                    chk("done_tvalid", 64'(m_axis_tvalid), 64'(0));
                    chk("done_busy", 64'(busy), 64'(0));
                end
            end
        end
    end

    task automatic issue(input int len, input logic [DW-1:0] sd, input bit push);
        start     = 1'b1;
        frame_len = LW'(len);
        seed      = sd;
        if (push && len != 0) begin
            for (int k = 0; k < len; k++)
                exp_beats.push_back(beat_t'({sd + DW'(k), (k == len - 1)}));
            model_cnt = model_cnt + CW'(1);
            exp_done.push_back(model_cnt);
        end
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2;
        areset = 1'b1;
        exp_beats.delete();
        exp_done.delete();
        model_cnt = '0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int            base;
    int            n;
    logic          pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [CW-1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_frames_sent", 64'(frames_sent), 64'(0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;

        // Reset mid-frame after three handshakes
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        issue(8, 32'h10, 1'b1);
        base = hs;
        n = 0;
        while (hs < base + 3 && n < 50) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk("mid_hs", 64'(hs - base), 64'(3));
        chk("mid_pre_valid", 64'(m_axis_tvalid), 64'(1));
        #1;
        areset = 1'b1;
        exp_beats.delete();
        exp_done.delete();
        model_cnt = '0;
        #1;
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_tlast", 64'(m_axis_tlast), 64'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("mid_after_busy", 64'(busy), 64'(0));
        chk("mid_after_done", 64'(done), 64'(0));
        chk("mid_after_cnt", 64'(frames_sent), 64'(0));

        // Full throughput with data wrap
        issue(4, 32'hFFFF_FFFE, 1'b1);
        chk("ft_first_data", 64'(m_axis_tdata), 64'h0000_0000_FFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            chk("ft_valid", 64'(m_axis_tvalid), 64'(1));
            chk("ft_last", 64'(m_axis_tlast), 64'(i == 3));
            @(posedge aclk);
            #1;
        end
        chk("ft_done", 64'(done), 64'(1));
        chk("ft_end_valid", 64'(m_axis_tvalid), 64'(0));
        chk("ft_end_tlast", 64'(m_axis_tlast), 64'(0));
        chk("ft_end_busy", 64'(busy), 64'(0));
        chk("ft_cnt", 64'(frames_sent), 64'(1));
        @(posedge aclk);
        #1;
        chk("ft_done_pulse", 64'(done), 64'(0));

        // Backpressure pattern 0,0,1,0,1,1
        m_axis_tready = 1'b0;
        issue(3, 32'd5, 1'b1);
        base = hs;
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = pat[i];
            @(posedge aclk);
            #1;
        end
        chk("bp_handshakes", 64'(hs - base), 64'(3));
        chk("bp_done", 64'(done), 64'(1));
        m_axis_tready = 1'b1;

        // start during SEND ignored; start in done cycle accepted
        issue(3, 32'h100, 1'b1);
        issue(5, 32'h999, 1'b0);
        wait_done("sh_a");
        issue(2, 32'h200, 1'b1);
        chk("sh_b_busy", 64'(busy), 64'(1));
        chk("sh_b_valid", 64'(m_axis_tvalid), 64'(1));
        chk("sh_b_data", 64'(m_axis_tdata), 64'h200);
        wait_done("sh_b");

        // Edge lengths: 0 ignored, 1 is a single tlast beat
        do_reset();
        issue(0, 32'h77, 1'b1);
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_valid", 64'(m_axis_tvalid), 64'(0));
        repeat (3) @(posedge aclk);
        #1;
        chk("len0_done", 64'(done), 64'(0));
        chk("len0_cnt", 64'(frames_sent), 64'(0));
        issue(1, 32'hAB, 1'b1);
        chk("len1_valid", 64'(m_axis_tvalid), 64'(1));
        chk("len1_last", 64'(m_axis_tlast), 64'(1));
        wait_done("len1");
        chk("len1_cnt", 64'(frames_sent), 64'(1));

        // Counter wrap with a 2-bit count
        do_reset();
        for (int f = 0; f < 5; f++) begin
            issue(2, DW'(f * 16), 1'b1);
            wait_done("wrap");
            chk("wrap_cnt", 64'(frames_sent), 64'(wrap_exp[f]));
        end

        repeat (3) @(posedge aclk);
        #1;
        chk("sb_beats_empty", 64'(exp_beats.size()), 64'(0));
        chk("sb_done_empty", 64'(exp_done.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
